// File: rtl/icache_ctrl.sv
// Fetch-side sequencer for a direct-mapped icache: lookup, single-beat refill over req/ack, core response.
// Optional hit/miss performance counters are built when ICACHE_CTRL_PERF_EN is defined.
module icache_ctrl #(
  parameter int ADDR_SIZE = 32,
  parameter int LINE_SIZE = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 fetch_req_i,
  input  logic [ADDR_SIZE-1:0] pc_i,
  input  logic                 flush_i,
  output logic [LINE_SIZE-1:0] inst_o,
  output logic                 inst_valid_o,
  output logic                 fetch_err_o,
  output logic                 stall_o,
  output logic [ADDR_SIZE-1:0] cache_pc_o,
  output logic                 cache_re_o,
  output logic                 cache_we_o,
  output logic [LINE_SIZE-1:0] cache_inst_o,
  input  logic [LINE_SIZE-1:0] cache_inst_i,
  input  logic                 cache_hit_i,
  output logic                 mem_req_o,
  output logic [ADDR_SIZE-1:0] mem_addr_o,
  input  logic                 mem_ack_i,
  input  logic [LINE_SIZE-1:0] mem_data_i,
  input  logic                 mem_err_i,
  output logic [CNT_WIDTH-1:0] hit_cnt_o,
  output logic [CNT_WIDTH-1:0] miss_cnt_o
);

  // Memory handshake: mem_req_o and mem_addr_o stay stable from assertion until the
  // cycle mem_ack_i is sampled high; mem_ack_i is ignored whenever mem_req_o is low.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    REFILL = 2'd2,
    DRAIN  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [ADDR_SIZE-1:0] pc_q, pc_d;
  logic [ADDR_SIZE-1:0] line_addr;

  assign line_addr = {pc_q[ADDR_SIZE-1:2], 2'b00};
  assign stall_o   = (state_q != IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    cache_pc_o   = pc_q;
    cache_re_o   = 1'b0;
    cache_we_o   = 1'b0;
    cache_inst_o = '0;
    inst_o       = '0;
    inst_valid_o = 1'b0;
    fetch_err_o  = 1'b0;
    mem_req_o    = 1'b0;
    mem_addr_o   = '0;
    case (state_q)
      IDLE: begin
        cache_pc_o = pc_i;
        cache_re_o = fetch_req_i;
        if (fetch_req_i) begin
          pc_d    = pc_i;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        cache_re_o = 1'b1;
        if (flush_i) begin
          state_d = IDLE;
        end else if (cache_hit_i) begin
          inst_o       = cache_inst_i;
          inst_valid_o = 1'b1;
          state_d      = IDLE;
        end else begin
          state_d = REFILL;
        end
      end
      REFILL: begin
        mem_req_o  = 1'b1;
        mem_addr_o = line_addr;
        if (mem_ack_i) begin
          // A flush racing the ack still fills the line, it only drops the core response.
          if (!mem_err_i) begin
            cache_we_o   = 1'b1;
            cache_inst_o = mem_data_i;
          end
          if (!flush_i) begin
            inst_valid_o = 1'b1;
            fetch_err_o  = mem_err_i;
            inst_o       = mem_err_i ? '0 : mem_data_i;
          end
          state_d = IDLE;
        end else if (flush_i) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Request must complete before the bus is released; no core response.
        mem_req_o  = 1'b1;
        mem_addr_o = line_addr;
        if (mem_ack_i) begin
          if (!mem_err_i) begin
            cache_we_o   = 1'b1;
            cache_inst_o = mem_data_i;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef ICACHE_CTRL_PERF_EN
  logic                 hit_ev, miss_ev;
  logic [CNT_WIDTH-1:0] hit_cnt_q, miss_cnt_q;

  assign hit_ev  = (state_q == LOOKUP) && !flush_i && cache_hit_i;
  assign miss_ev = (state_q == LOOKUP) && !flush_i && !cache_hit_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_ev && (hit_cnt_q != '1)) hit_cnt_q <= hit_cnt_q + CNT_WIDTH'(1);
      if (miss_ev && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`else
  assign hit_cnt_o  = '0;
  assign miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Bench for icache_ctrl: emulated cache array and memory, randomized fetches checked
// against an address-level model of cache contents through an expected-response queue.
module tb_icache_ctrl;

  logic        clk;
  logic        rst_n;
  logic        fetch_req;
  logic [31:0] pc;
  logic        flush;
  logic [31:0] inst;
  logic        inst_valid;
  logic        fetch_err;
  logic        stall;
  logic [31:0] cache_pc;
  logic        cache_re;
  logic        cache_we;
  logic [31:0] cache_wdata;
  logic [31:0] cache_rdata;
  logic        cache_hit;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic        mem_err;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  icache_ctrl #(.ADDR_SIZE(32), .LINE_SIZE(32), .CNT_WIDTH(32)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .fetch_req_i  (fetch_req),
    .pc_i         (pc),
    .flush_i      (flush),
    .inst_o       (inst),
    .inst_valid_o (inst_valid),
    .fetch_err_o  (fetch_err),
    .stall_o      (stall),
    .cache_pc_o   (cache_pc),
    .cache_re_o   (cache_re),
    .cache_we_o   (cache_we),
    .cache_inst_o (cache_wdata),
    .cache_inst_i (cache_rdata),
    .cache_hit_i  (cache_hit),
    .mem_req_o    (mem_req),
    .mem_addr_o   (mem_addr),
    .mem_ack_i    (mem_ack),
    .mem_data_i   (mem_data),
    .mem_err_i    (mem_err),
    .hit_cnt_o    (hit_cnt),
    .miss_cnt_o   (miss_cnt)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Emulated direct-mapped cache array (64 lines), written only by the DUT or a preload
  bit        cv [64];
  bit [23:0] ct [64];
  bit [31:0] cd [64];
  logic       pl_en;
  logic [31:0] pl_addr;
  logic [31:0] pl_data;
  logic [5:0]  cidx;

  assign cidx        = cache_pc[7:2];
  assign cache_hit   = cv[cidx] && (ct[cidx] == cache_pc[31:8]);
  assign cache_rdata = cd[cidx];

  always @(posedge clk) begin
    if (cache_we) begin
      cv[cidx] <= 1'b1;
      ct[cidx] <= cache_pc[31:8];
      cd[cidx] <= cache_wdata;
    end else if (pl_en) begin
      cv[pl_addr[7:2]] <= 1'b1;
      ct[pl_addr[7:2]] <= pl_addr[31:8];
      cd[pl_addr[7:2]] <= pl_data;
    end
  end

  // Reference model: which word addresses the cache should hold, and counter totals
  logic [31:0] model_mem [logic [29:0]];
  int          n_hit;
  int          n_miss;

  // Scoreboard: {err, inst}
  logic [32:0] exp_q [$];
  int          checks;
  int          errors;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] cnt_exp(input int n);
    int e;
    e = n;
`ifndef ICACHE_CTRL_PERF_EN
    e = 0;
`endif
    return 32'(e);
  endfunction

  task automatic check_cnt(input string tag);
    check({tag, "_hit_cnt"}, hit_cnt, cnt_exp(n_hit));
    check({tag, "_miss_cnt"}, miss_cnt, cnt_exp(n_miss));
  endtask

  // Monitor: pops one expectation per inst_valid pulse, sampled just before the rising edge
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      #4;
      if (inst_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got inst=%h err=%b expected no response at %0t",
                   inst, fetch_err, $time);
        end else begin
          e = exp_q.pop_front();
          check("resp_inst", inst, e[31:0]);
          check("resp_err", fetch_err, e[32]);
        end
      end
    end
  end

  // Driver tasks: each starts and ends at a falling edge
  task automatic preload(input logic [31:0] addr, input logic [31:0] data);
    pl_en   = 1'b1;
    pl_addr = addr;
    pl_data = data;
    model_mem[addr[31:2]] = data;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // flush_at: 0 none, 1 in LOOKUP, 2 in first refill cycle, 3 in the ack cycle
  task automatic fetch(input logic [31:0] addr, input int flush_at, input int lat,
                       input logic [31:0] data, input logic err);
    logic        hit;
    logic [31:0] line;
    hit  = model_mem.exists(addr[31:2]);
    line = '0;
    if (hit) line = model_mem[addr[31:2]];
    fetch_req = 1'b1;
    pc        = addr;
    #4;
    check("accept_stall", stall, 0);
    check("idle_mem_req", mem_req, 0);
    check("idle_cache_pc", cache_pc, addr);
    @(negedge clk);
    fetch_req = 1'b0;
    pc        = $urandom();
    flush     = (flush_at == 1);
    if (hit) begin
      if (flush_at != 1) begin
        exp_q.push_back({1'b0, line});
        n_hit++;
      end
      #4;
      check("lookup_valid", inst_valid, flush_at != 1);
      check("lookup_mem_req", mem_req, 0);
      @(negedge clk);
      flush = 1'b0;
      return;
    end
    if (flush_at != 1) n_miss++;
    #4;
    check("miss_lookup_valid", inst_valid, 0);
    check("lookup_stall", stall, 1);
    @(negedge clk);
    flush = 1'b0;
    if (flush_at == 1) return;
    for (int c = 0; c < lat; c++) begin
      flush = (c == 0 && flush_at == 2);
      #4;
      check("refill_req", mem_req, 1);
      check("refill_addr", mem_addr, {addr[31:2], 2'b00});
      check("refill_we", cache_we, 0);
      @(negedge clk);
      flush = 1'b0;
    end
    mem_ack  = 1'b1;
    mem_data = data;
    mem_err  = err;
    flush    = (flush_at == 3);
    if (flush_at == 0) exp_q.push_back(err ? {1'b1, 32'h0} : {1'b0, data});
    if (!err) model_mem[addr[31:2]] = data;
    #4;
    check("ack_req", mem_req, 1);
    check("ack_we", cache_we, !err);
    if (!err) check("ack_wdata", cache_wdata, data);
    @(negedge clk);
    mem_ack  = 1'b0;
    mem_err  = 1'b0;
    flush    = 1'b0;
    mem_data = $urandom();
  endtask

  initial begin
    int          r;
    int          fa;
    int          lat;
    logic [31:0] a;
    checks    = 0;
    errors    = 0;
    n_hit     = 0;
    n_miss    = 0;
    rst_n     = 1'b0;
    fetch_req = 1'b0;
    pc        = 32'h1234_5678;
    flush     = 1'b0;
    mem_ack   = 1'b0;
    mem_data  = '0;
    mem_err   = 1'b0;
    pl_en     = 1'b0;
    pl_addr   = '0;
    pl_data   = '0;
    #1;
    check("rst_cache_pc", cache_pc, 32'h1234_5678);
    check("rst_stall", stall, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_valid", inst_valid, 0);
    check("rst_cache_re", cache_re, 0);
    check("rst_cache_we", cache_we, 0);
    check_cnt("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Hit on a preloaded line
    preload(32'h4, 32'hcafe_0004);
    fetch(32'h4, 0, 0, 32'h0, 1'b0);
    check_cnt("hit");

    // Cold miss, then refetch hits
    fetch(32'h400, 0, 3, 32'h0050_0093, 1'b0);
    check_cnt("miss");
    fetch(32'h400, 0, 0, 32'h0, 1'b0);

    // Bus error: no fill, refetch misses again
    fetch(32'h408, 0, 2, 32'h1111_2222, 1'b1);
    fetch(32'h40a, 0, 1, 32'h3333_4444, 1'b0);

    // Flush during refill, ack four cycles later; next fetch accepted right after
    fetch(32'h40c, 2, 4, 32'h5555_6666, 1'b0);
    fetch(32'h40c, 0, 0, 32'h0, 1'b0);

    // Flush on a lookup hit
    fetch(32'h400, 1, 0, 32'h0, 1'b0);
    check_cnt("flush");

    // Flush together with the ack
    fetch(32'h410, 3, 2, 32'h7777_8888, 1'b0);
    fetch(32'h410, 0, 0, 32'h0, 1'b0);

    // Stray ack while idle is ignored
    mem_ack  = 1'b1;
    mem_data = 32'hdead_beef;
    #4;
    check("stray_we", cache_we, 0);
    check("stray_req", mem_req, 0);
    @(negedge clk);
    mem_ack = 1'b0;

    // Asynchronous reset in the middle of a refill
    fetch_req = 1'b1;
    pc        = 32'h470;
    @(negedge clk);
    fetch_req = 1'b0;
    @(negedge clk);
    #2;
    check("pre_rst_req", mem_req, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_req", mem_req, 0);
    check("async_rst_stall", stall, 0);
    check("async_rst_valid", inst_valid, 0);
    n_hit  = 0;
    n_miss = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #4;
    check("post_rst_stall", stall, 0);
    check_cnt("post_rst");
    @(negedge clk);

    // Randomized traffic over a pool of non-conflicting lines
    for (int i = 0; i < 80; i++) begin
      a   = 32'h400 + 32'(4 * $urandom_range(2, 31)) + 32'($urandom_range(0, 3));
      r   = $urandom_range(0, 9);
      fa  = (r < 7) ? 0 : r - 6;
      lat = $urandom_range(0, 4);
      if (fa == 2 && lat == 0) lat = 1;
      fetch(a, fa, lat, $urandom(), ($urandom_range(0, 7) == 0));
      check_cnt("rand");
    end

    @(negedge clk);
    @(negedge clk);
    check("pending_responses", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/icache_ctrl.md
# icache_ctrl

Fetch-side sequencer for the direct-mapped instruction cache. It accepts fetch requests from the core and drives the cache's address, read and write ports. On a miss it runs a single-beat refill from instruction memory over a req/ack handshake, writes the returned line into the cache, and delivers it to the core. It sits between the fetch stage, the icache array and the memory/bus interface, and provides the core's fetch stall.

## Interface
Parameters:
- ADDR_SIZE, 32, fetch/memory address width
- LINE_SIZE, 32, cache line width (one instruction)
- CNT_WIDTH, 32, performance counter width (used only with ICACHE_CTRL_PERF_EN)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- fetch_req_i  in  1  core requests the instruction at pc_i
- pc_i  in  ADDR_SIZE  fetch address
- flush_i  in  1  abort the outstanding fetch (branch redirect)
- inst_o  out  LINE_SIZE  fetched instruction
- inst_valid_o  out  1  inst_o / fetch_err_o valid, one-cycle pulse
- fetch_err_o  out  1  fetch ended in a bus error (qualified by inst_valid_o)
- stall_o  out  1  controller busy; new requests not accepted
- cache_pc_o  out  ADDR_SIZE  cache address bus
- cache_re_o  out  1  cache read enable
- cache_we_o  out  1  cache write enable
- cache_inst_o  out  LINE_SIZE  cache write data
- cache_inst_i  in  LINE_SIZE  cache read data
- cache_hit_i  in  1  cache hit flag
- mem_req_o  out  1  refill request
- mem_addr_o  out  ADDR_SIZE  refill address, bits [1:0] forced to 0
- mem_ack_i  in  1  refill data valid, single-cycle pulse
- mem_data_i  in  LINE_SIZE  refill data
- mem_err_i  in  1  bus error, qualified by mem_ack_i
- hit_cnt_o, miss_cnt_o  out  CNT_WIDTH  performance counters

## Operation
- States: IDLE, LOOKUP, REFILL, DRAIN. pc_q holds the accepted address.
- IDLE:
  - cache_pc_o = pc_i, cache_re_o = fetch_req_i.
  - If fetch_req_i: latch pc_q, go to LOOKUP.
- LOOKUP:
  - cache_pc_o = pc_q, cache_re_o = 1.
  - flush_i has priority: go to IDLE, no response.
  - Else if cache_hit_i: inst_o = cache_inst_i, inst_valid_o = 1, go to IDLE.
  - Else: go to REFILL.
- REFILL:
  - mem_req_o = 1, mem_addr_o = {pc_q[ADDR_SIZE-1:2], 2'b00}, cache_pc_o = pc_q.
  - On mem_ack_i with !mem_err_i, in the same cycle: cache_we_o = 1, cache_inst_o = mem_data_i, inst_o = mem_data_i, inst_valid_o = 1. Then go to IDLE.
  - On mem_ack_i with mem_err_i: no cache write, inst_o = 0, inst_valid_o = 1, fetch_err_o = 1. Then go to IDLE.
  - flush_i without mem_ack_i: go to DRAIN.
  - flush_i together with mem_ack_i: write the cache if no error, suppress inst_valid_o, go to IDLE.
- DRAIN:
  - mem_req_o stays 1 until mem_ack_i.
  - On ack: write the cache if no error, no core response, go to IDLE.
  - Further flush_i is ignored.
- stall_o = (state != IDLE).
- mem_ack_i is ignored while mem_req_o = 0.

## Timing
- Reset: state IDLE, pc_q = 0. All outputs 0, except cache_pc_o, which follows pc_i combinationally in IDLE.
- Hit latency: request accepted at edge N, inst_valid_o high during cycle N+1. Throughput is one fetch per 2 cycles.
- Miss latency: 2 cycles + memory latency; inst_valid_o is asserted in the mem_ack_i cycle.
- Handshake:
  - mem_req_o and mem_addr_o are held stable from assertion until the cycle mem_ack_i is sampled high.
  - mem_req_o drops in the following cycle.
  - mem_req_o never deasserts without an ack, including on flush.
- The core must hold fetch_req_i and pc_i until a cycle with stall_o = 0.
- Asynchronous reset mid-refill returns to IDLE immediately. The memory side must tolerate the abandoned request.

## Configuration
- ICACHE_CTRL_PERF_EN defined:
  - hit_cnt_o increments on every LOOKUP hit that is not flushed.
  - miss_cnt_o increments on every LOOKUP miss that is not flushed.
  - Both are saturating at all-ones and reset to 0.
- ICACHE_CTRL_PERF_EN undefined: no counter flops; hit_cnt_o and miss_cnt_o are tied to 0.

## Test plan
- Preloaded line, fetch pc=0x4 -> inst_valid_o on cycle 2 with cached data, no mem_req_o, hit_cnt_o = 1.
- Cold fetch pc=0x400, memory acks after 3 cycles with 0x00500093:
  - mem_addr_o = 0x400; cache_we_o and inst_valid_o both pulse in the ack cycle; miss_cnt_o = 1.
  - A refetch of 0x400 then hits in 2 cycles.
- Miss with mem_err_i on ack -> fetch_err_o = 1, inst_o = 0, no cache_we_o; a refetch misses again.
- flush_i during REFILL with ack 4 cycles later:
  - mem_req_o is held until ack, cache is written, no inst_valid_o.
  - The next request is accepted in the cycle after the ack.
- flush_i in LOOKUP on a hit -> no inst_valid_o, counters unchanged, stall_o low the next cycle.
- rst_ni asserted low mid-REFILL -> mem_req_o, stall_o and inst_valid_o read 0 immediately; state is IDLE on release.
